// File: rtl/barrel_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation modes and
// the reserved-mode test used by the output flag logic.
package barrel_shifter_pkg;

  typedef enum logic [2:0] {
    MODE_SLL = 3'd0,
    MODE_SRL = 3'd1,
    MODE_SRA = 3'd2,
    MODE_ROL = 3'd3,
    MODE_ROR = 3'd4
  } mode_e;

  function automatic logic mode_is_reserved(input logic [2:0] m);
    return m > MODE_ROR;
  endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// One pipeline stage of the barrel shifter: conditionally shifts or rotates by
// 2**STAGE and registers data together with its valid, amount and mode.
module barrel_shift_stage
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STAGE = 0,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             prev_vld,
  input  logic [WIDTH-1:0] prev_data,
  input  logic [SHW-1:0]   prev_amt,
  input  logic [2:0]       prev_mode,
  output logic             vld,
  output logic [WIDTH-1:0] data,
  output logic [SHW-1:0]   amt,
  output logic [2:0]       mode,
  output logic [WIDTH-1:0] shifted
);

  localparam int DIST = 1 << STAGE;

  // SRA keeps the current MSB, which is the operand's original sign because
  // earlier SRA stages never change it. Reserved modes pass through.
  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] d,
                                                  input logic [2:0]       m);
    logic signed [WIDTH-1:0] sd;
    sd = d;
    case (m)
      MODE_SLL: return d << DIST;
      MODE_SRL: return d >> DIST;
      MODE_SRA: return sd >>> DIST;
      MODE_ROL: return (d << DIST) | (d >> (WIDTH - DIST));
      MODE_ROR: return (d >> DIST) | (d << (WIDTH - DIST));
      default:  return d;
    endcase
  endfunction

  assign shifted = prev_amt[STAGE] ? shift_once(prev_data, prev_mode) : prev_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld  <= 1'b0;
      data <= '0;
      amt  <= '0;
      mode <= '0;
    end else if (en) begin
      vld  <= prev_vld;
      data <= shifted;
      amt  <= prev_amt;
      mode <= prev_mode;
    end
  end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined shift/rotate unit, one stage per amount bit, with a global stall
// driven by the consumer and registered zero/error flags on the last stage.
module barrel_shifter_pipe
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_err
);

  logic             adv;
  logic             vld_p  [SHW+1];
  logic [WIDTH-1:0] data_p [SHW+1];
  logic [SHW-1:0]   amt_p  [SHW+1];
  logic [2:0]       mode_p [SHW+1];
  logic [WIDTH-1:0] shf_last;
  logic             zero_q;
  logic             err_q;
  logic             unused_tail;

  // Whole pipe stalls together; bubbles stay in place.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  assign vld_p[0]  = in_valid;
  assign data_p[0] = in_data;
  assign amt_p[0]  = in_amt;
  assign mode_p[0] = in_mode;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    logic [WIDTH-1:0] shf;

    barrel_shift_stage #(
      .WIDTH (WIDTH),
      .STAGE (k),
      .SHW   (SHW)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (adv),
      .prev_vld  (vld_p[k]),
      .prev_data (data_p[k]),
      .prev_amt  (amt_p[k]),
      .prev_mode (mode_p[k]),
      .vld       (vld_p[k+1]),
      .data      (data_p[k+1]),
      .amt       (amt_p[k+1]),
      .mode      (mode_p[k+1]),
      .shifted   (shf)
    );

    if (k == SHW - 1) begin : g_last
      assign shf_last = shf;
    end else begin : g_mid
      logic unused_shf;
      assign unused_shf = ^shf;
    end
  end

  assign unused_tail = ^{amt_p[SHW], mode_p[SHW]};

  // Final stage boundary: flags load with the last data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (adv) begin
      zero_q <= vld_p[SHW-1] & (shf_last == '0);
      err_q  <= vld_p[SHW-1] & mode_is_reserved(mode_p[SHW-1]);
    end
  end

  assign out_valid = vld_p[SHW];
  assign out_data  = data_p[SHW];
  assign out_zero  = zero_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Scoreboard bench for barrel_shifter_pipe at WIDTH=8 and WIDTH=32.
module tb_barrel_shifter_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid8, in_ready8, out_valid8, out_ready8, out_zero8, out_err8;
  logic [7:0] in_data8, out_data8;
  logic [2:0] in_amt8, in_mode8;

  logic        in_valid32, in_ready32, out_valid32, out_ready32, out_zero32, out_err32;
  logic [31:0] in_data32, out_data32;
  logic [4:0]  in_amt32;
  logic [2:0]  in_mode32;

  barrel_shifter_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_data(in_data8), .in_amt(in_amt8), .in_mode(in_mode8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .out_zero(out_zero8), .out_err(out_err8)
  );

  barrel_shifter_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .in_data(in_data32), .in_amt(in_amt32), .in_mode(in_mode32),
    .out_valid(out_valid32), .out_ready(out_ready32), .out_data(out_data32),
    .out_zero(out_zero32), .out_err(out_err32)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [9:0]  exp8[$],  got8[$];
  logic [33:0] exp32[$], got32[$];
  int acc_cyc8[$], out_cyc8[$];

  // Reference: {err, zero, data} for a whole shift in one step.
  function automatic logic [9:0] model8(logic [7:0] d, logic [2:0] a, logic [2:0] m);
    logic [7:0] r;
    logic signed [7:0] sd;
    sd = d;
    case (m)
      3'd0: r = d << a;
      3'd1: r = d >> a;
      3'd2: r = sd >>> a;
      3'd3: r = (d << a) | (d >> (8 - int'(a)));
      3'd4: r = (d >> a) | (d << (8 - int'(a)));
      default: r = d;
    endcase
    return {m > 3'd4, r == 8'd0, r};
  endfunction

  function automatic logic [33:0] model32(logic [31:0] d, logic [4:0] a, logic [2:0] m);
    logic [31:0] r;
    logic signed [31:0] sd;
    sd = d;
    case (m)
      3'd0: r = d << a;
      3'd1: r = d >> a;
      3'd2: r = sd >>> a;
      3'd3: r = (d << a) | (d >> (32 - int'(a)));
      3'd4: r = (d >> a) | (d << (32 - int'(a)));
      default: r = d;
    endcase
    return {m > 3'd4, r == 32'd0, r};
  endfunction

  // Advance one clock, logging accepted inputs (as model results) and popped outputs.
  task automatic tick();
    #1;
    if (!rst) begin
      if (in_valid8 && in_ready8) begin
        exp8.push_back(model8(in_data8, in_amt8, in_mode8));
        acc_cyc8.push_back(cyc);
      end
      if (out_valid8 && out_ready8) begin
        got8.push_back({out_err8, out_zero8, out_data8});
        out_cyc8.push_back(cyc);
      end
      if (in_valid32 && in_ready32) exp32.push_back(model32(in_data32, in_amt32, in_mode32));
      if (out_valid32 && out_ready32) got32.push_back({out_err32, out_zero32, out_data32});
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle_inputs();
    in_valid8 = 1'b0; in_data8 = '0; in_amt8 = '0; in_mode8 = '0; out_ready8 = 1'b1;
    in_valid32 = 1'b0; in_data32 = '0; in_amt32 = '0; in_mode32 = '0; out_ready32 = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    out_ready8 = 1'b0; out_ready32 = 1'b0;
    rst = 1'b1;
    tick(); tick();
    checks += 2;
    if ({out_valid8, out_zero8, out_err8, out_data8} !== 11'd0) begin
      errors++; $display("FAIL reset_out8: got %h expected 000", {out_valid8, out_zero8, out_err8, out_data8});
    end
    if ({out_valid32, out_zero32, out_err32, out_data32} !== 35'd0) begin
      errors++; $display("FAIL reset_out32: got %h expected 0", {out_valid32, out_zero32, out_err32, out_data32});
    end
    rst = 1'b0;
    tick();
    checks += 2;
    if (in_ready8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready8: got %b expected 1", in_ready8); end
    if (in_ready32 !== 1'b1) begin errors++; $display("FAIL reset_in_ready32: got %b expected 1", in_ready32); end
    idle_inputs();
  endtask

  typedef struct {
    logic [7:0] d; logic [2:0] a; logic [2:0] m; logic [7:0] e; logic z; logic er;
  } vec_t;

  task automatic test_directed();
    vec_t tbl [14];
    logic [9:0] g;
    tbl = '{'{8'h80, 3'd4, 3'd0, 8'h00, 1'b1, 1'b0}, '{8'h80, 3'd4, 3'd1, 8'h08, 1'b0, 1'b0},
            '{8'h80, 3'd2, 3'd2, 8'hE0, 1'b0, 1'b0}, '{8'h40, 3'd2, 3'd2, 8'h10, 1'b0, 1'b0},
            '{8'h81, 3'd1, 3'd3, 8'h03, 1'b0, 1'b0}, '{8'h01, 3'd7, 3'd4, 8'h02, 1'b0, 1'b0},
            '{8'hFF, 3'd7, 3'd4, 8'hFF, 1'b0, 1'b0}, '{8'hA5, 3'd0, 3'd0, 8'hA5, 1'b0, 1'b0},
            '{8'hA5, 3'd0, 3'd1, 8'hA5, 1'b0, 1'b0}, '{8'hA5, 3'd0, 3'd2, 8'hA5, 1'b0, 1'b0},
            '{8'hA5, 3'd0, 3'd3, 8'hA5, 1'b0, 1'b0}, '{8'hA5, 3'd0, 3'd4, 8'hA5, 1'b0, 1'b0},
            '{8'h5A, 3'd3, 3'd6, 8'h5A, 1'b0, 1'b1}, '{8'h01, 3'd1, 3'd0, 8'h02, 1'b0, 1'b0}};
    got8.delete(); exp8.delete();
    for (int i = 0; i < 14; i++) begin
      in_valid8 = 1'b1; in_data8 = tbl[i].d; in_amt8 = tbl[i].a; in_mode8 = tbl[i].m;
      tick();
    end
    in_valid8 = 1'b0;
    for (int i = 0; i < 40 && got8.size() < 14; i++) tick();
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (got8.size() == 0) begin
        errors++; $display("FAIL directed_%0d: got no result expected %h", i, {tbl[i].er, tbl[i].z, tbl[i].e});
      end else begin
        g = got8.pop_front();
        if (g !== {tbl[i].er, tbl[i].z, tbl[i].e}) begin
          errors++; $display("FAIL directed_%0d: got err/zero/data %h expected %h", i, g, {tbl[i].er, tbl[i].z, tbl[i].e});
        end
      end
    end
    exp8.delete(); got8.delete();
  endtask

  task automatic test_back_to_back();
    logic [9:0] e, g;
    int n;
    exp8.delete(); got8.delete(); acc_cyc8.delete(); out_cyc8.delete();
    for (int i = 0; i < 16; i++) begin
      in_valid8 = 1'b1; in_data8 = 8'(i * 37 + 1); in_amt8 = 3'(i); in_mode8 = 3'(i % 5);
      tick();
    end
    in_valid8 = 1'b0;
    for (int i = 0; i < 40 && got8.size() < exp8.size(); i++) tick();
    checks += 3;
    if (acc_cyc8.size() != 16 || out_cyc8.size() != 16) begin
      errors++; $display("FAIL b2b_count: got acc %0d out %0d expected 16 16", acc_cyc8.size(), out_cyc8.size());
    end else begin
      if (out_cyc8[0] - acc_cyc8[0] != 3) begin
        errors++; $display("FAIL b2b_latency: got %0d expected 3", out_cyc8[0] - acc_cyc8[0]);
      end
      if (out_cyc8[15] - out_cyc8[0] != 15) begin
        errors++; $display("FAIL b2b_rate: got %0d cycles expected 15", out_cyc8[15] - out_cyc8[0]);
      end
    end
    n = exp8.size();
    for (int i = 0; i < n; i++) begin
      e = exp8.pop_front(); checks++;
      if (got8.size() == 0) begin errors++; $display("FAIL b2b_beat_%0d: got none expected %h", i, e); end
      else begin
        g = got8.pop_front();
        if (g !== e) begin errors++; $display("FAIL b2b_beat_%0d: got %h expected %h", i, g, e); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] hold;
    logic [9:0] e, g;
    int n;
    exp8.delete(); got8.delete();
    for (int i = 0; i < 4; i++) begin
      in_valid8 = 1'b1; in_data8 = 8'($urandom); in_amt8 = 3'($urandom); in_mode8 = 3'($urandom_range(0, 4));
      tick();
    end
    out_ready8 = 1'b0; in_data8 = 8'h3C;
    hold = out_data8;
    checks++;
    if (out_valid8 !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b expected 1", out_valid8); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks += 2;
      if (in_ready8 !== 1'b0) begin errors++; $display("FAIL stall_in_ready_%0d: got %b expected 0", i, in_ready8); end
      if (out_data8 !== hold) begin errors++; $display("FAIL stall_hold_%0d: got %h expected %h", i, out_data8, hold); end
    end
    // Random producer/consumer pattern on both widths.
    for (int i = 0; i < 300; i++) begin
      in_valid8 = ($urandom % 4) != 0; out_ready8 = ($urandom % 3) != 0;
      in_data8 = 8'($urandom); in_amt8 = 3'($urandom); in_mode8 = 3'($urandom_range(0, 6));
      in_valid32 = ($urandom % 3) != 0; out_ready32 = ($urandom % 2) != 0;
      in_data32 = $urandom; in_amt32 = 5'($urandom); in_mode32 = 3'($urandom_range(0, 6));
      tick();
    end
    in_valid8 = 1'b0; out_ready8 = 1'b1; in_valid32 = 1'b0; out_ready32 = 1'b1;
    for (int i = 0; i < 40 && (got8.size() < exp8.size() || got32.size() < exp32.size()); i++) tick();
    n = exp8.size();
    for (int i = 0; i < n; i++) begin
      e = exp8.pop_front(); checks++;
      if (got8.size() == 0) begin errors++; $display("FAIL bp8_beat_%0d: got none expected %h", i, e); end
      else begin
        g = got8.pop_front();
        if (g !== e) begin errors++; $display("FAIL bp8_beat_%0d: got %h expected %h", i, g, e); end
      end
    end
    checks++;
    if (got8.size() != 0) begin errors++; $display("FAIL bp8_extra: got %0d extra beats expected 0", got8.size()); end
    n = exp32.size();
    for (int i = 0; i < n; i++) begin
      logic [33:0] e32, g32;
      e32 = exp32.pop_front(); checks++;
      if (got32.size() == 0) begin errors++; $display("FAIL bp32_beat_%0d: got none expected %h", i, e32); end
      else begin
        g32 = got32.pop_front();
        if (g32 !== e32) begin errors++; $display("FAIL bp32_beat_%0d: got %h expected %h", i, g32, e32); end
      end
    end
    checks++;
    if (got32.size() != 0) begin errors++; $display("FAIL bp32_extra: got %0d extra beats expected 0", got32.size()); end
    idle_inputs();
  endtask

  task automatic test_wide();
    logic [33:0] e, g;
    int n;
    exp32.delete(); got32.delete();
    for (int m = 0; m < 7; m++) begin
      in_valid32 = 1'b1; in_data32 = 32'h8000_0001; in_amt32 = 5'd31; in_mode32 = 3'(m);
      tick();
      in_data32 = 32'hC3A5_0F96; in_amt32 = 5'd0;
      tick();
    end
    in_valid32 = 1'b0;
    for (int i = 0; i < 40 && got32.size() < exp32.size(); i++) tick();
    n = exp32.size();
    for (int i = 0; i < n; i++) begin
      e = exp32.pop_front(); checks++;
      if (got32.size() == 0) begin errors++; $display("FAIL wide_beat_%0d: got none expected %h", i, e); end
      else begin
        g = got32.pop_front();
        if (g !== e) begin errors++; $display("FAIL wide_beat_%0d: got %h expected %h", i, g, e); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    out_ready8 = 1'b0; out_ready32 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid8 = 1'b1; in_data8 = 8'h11 << i; in_amt8 = 3'd1; in_mode8 = 3'(i);
      in_valid32 = 1'b1; in_data32 = 32'h8000_0001 + i; in_amt32 = 5'd31; in_mode32 = 3'(i + 2);
      tick();
    end
    rst = 1'b1;
    tick();
    checks += 2;
    if (out_valid8 !== 1'b0) begin errors++; $display("FAIL midrst_valid8: got %b expected 0", out_valid8); end
    if (out_valid32 !== 1'b0) begin errors++; $display("FAIL midrst_valid32: got %b expected 0", out_valid32); end
    rst = 1'b0;
    idle_inputs();
    exp8.delete(); got8.delete(); exp32.delete(); got32.delete();
    for (int i = 0; i < 8; i++) tick();
    checks += 2;
    if (got8.size() != 0) begin errors++; $display("FAIL midrst_leak8: got %0d beats expected 0", got8.size()); end
    if (got32.size() != 0) begin errors++; $display("FAIL midrst_leak32: got %0d beats expected 0", got32.size()); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_wide();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
